// File: rtl/prior_encoder.sv
// Registered 4-to-2 priority encoder (i3 highest) with a valid flag and an
// optional input register stage for timing closure.
module prior_encoder #(
    parameter int REG_IN = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic i0,
    input  logic i1,
    input  logic i2,
    input  logic i3,
    output logic out1,
    output logic out2,
    output logic valid
);

    logic [3:0] req_raw;
    logic [3:0] req_enc;
    logic [1:0] idx_next;
    logic       valid_next;
    logic [1:0] idx_reg;
    logic       valid_reg;

    assign req_raw = {i3, i2, i1, i0};

    generate
        if (REG_IN != 0) begin : g_in_reg
            logic [3:0] req_reg;
            genvar gi;
            // Cleared on reset so no pre-reset sample can surface afterwards.
            for (gi = 0; gi < 4; gi++) begin : g_bit
                always_ff @(posedge clk) begin
                    if (rst) begin
                        req_reg[gi] <= 1'b0;
                    end else begin
                        req_reg[gi] <= req_raw[gi];
                    end
                end
            end
            assign req_enc = req_reg;
        end else begin : g_no_in_reg
            assign req_enc = req_raw;
        end
    endgenerate

    always_comb begin
        idx_next   = 2'b00;
        valid_next = |req_enc;
        if (req_enc[3]) begin
            idx_next = 2'b11;
        end else if (req_enc[2]) begin
            idx_next = 2'b10;
        end else if (req_enc[1]) begin
            idx_next = 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg   <= 2'b00;
            valid_reg <= 1'b0;
        end else begin
            idx_reg   <= idx_next;
            valid_reg <= valid_next;
        end
    end

    assign out1  = idx_reg[1];
    assign out2  = idx_reg[0];
    assign valid = valid_reg;

endmodule

// File: tb/tb_prior_encoder.sv
// Randomized self-checking bench for prior_encoder; both REG_IN variants run
// side by side against a history-based reference model.
module tb_prior_encoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i0 = 1'b0, i1 = 1'b0, i2 = 1'b0, i3 = 1'b0;
    logic a_out1, a_out2, a_valid;
    logic b_out1, b_out2, b_valid;

    int checks   = 0;
    int failures = 0;

    bit         hist_rst[$];
    logic [3:0] hist_in[$];

    always #5 clk = ~clk;

    prior_encoder #(.REG_IN(0)) dut0 (
        .clk(clk), .rst(rst), .i0(i0), .i1(i1), .i2(i2), .i3(i3),
        .out1(a_out1), .out2(a_out2), .valid(a_valid)
    );

    prior_encoder #(.REG_IN(1)) dut1 (
        .clk(clk), .rst(rst), .i0(i0), .i1(i1), .i2(i2), .i3(i3),
        .out1(b_out1), .out2(b_out2), .valid(b_valid)
    );

    task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got {out1,out2,valid}=%b expected %b", tag, got, exp);
        end
    endtask

    // Highest set request wins; result is {index, valid}.
    function automatic logic [2:0] encode(input logic [3:0] v);
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) return {i[1:0], 1'b1};
        end
        return 3'b000;
    endfunction

    // Output after the latest edge: zero if rst was seen within the pipeline
    // window, otherwise the encoding of the sample taken lat-1 edges earlier.
    function automatic logic [2:0] model(input int lat);
        int n;
        n = hist_in.size() - 1;
        for (int k = 0; k < lat; k++) begin
            if (n - k < 0) return 3'b000;
            if (hist_rst[n - k]) return 3'b000;
        end
        return encode(hist_in[n - lat + 1]);
    endfunction

    task automatic step(input string tag, input bit r, input logic [3:0] v);
        @(negedge clk);
        rst = r;
        {i3, i2, i1, i0} = v;
        @(posedge clk);
        hist_rst.push_back(r);
        hist_in.push_back(v);
        #1;
        check({tag, "/reg0"}, {a_out1, a_out2, a_valid}, model(1));
        check({tag, "/reg1"}, {b_out1, b_out2, b_valid}, model(2));
        $display("txn %-10s rst=%0b in=%b reg0=%b reg1=%b", tag, r, v,
                 {a_out1, a_out2, a_valid}, {b_out1, b_out2, b_valid});
    endtask

    initial begin
        logic [3:0] conflicts [4];
        conflicts[0] = 4'b0110;
        conflicts[1] = 4'b0011;
        conflicts[2] = 4'b1001;
        conflicts[3] = 4'b0101;

        step("reset", 1'b1, 4'b1111);
        step("reset", 1'b1, 4'b1111);
        check("reset_abs", {a_out1, a_out2, a_valid}, 3'b000);
        step("post_rst", 1'b0, 4'b1111);
        check("post_rst_abs", {a_out1, a_out2, a_valid}, 3'b111);
        check("post_rst_reg1_abs", {b_out1, b_out2, b_valid}, 3'b000);

        for (int i = 0; i < 4; i++) begin
            logic [3:0] oh;
            oh = 4'b0001 << i;
            step("onehot", 1'b0, oh);
        end
        for (int i = 0; i < 4; i++) step("conflict", 1'b0, conflicts[i]);

        step("zero", 1'b0, 4'b0000);
        check("zero_abs", {a_out1, a_out2, a_valid}, 3'b000);
        step("i0_only", 1'b0, 4'b0001);
        check("i0_only_abs", {a_out1, a_out2, a_valid}, 3'b001);

        for (int i = 0; i < 100; i++) step("random", 1'b0, 4'($urandom_range(0, 15)));

        for (int i = 0; i < 10; i++) step("pre_mid", 1'b0, 4'($urandom_range(1, 15)));
        step("mid_rst", 1'b1, 4'($urandom_range(1, 15)));
        check("mid_rst_abs", {a_out1, a_out2, a_valid}, 3'b000);
        for (int i = 0; i < 10; i++) step("post_mid", 1'b0, 4'($urandom_range(0, 15)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
